// File: rtl/sprite_blitter_pkg.sv
// Shared constants, state encoding and helpers for the sprite blitter slice.
package sprite_blitter_pkg;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;
  localparam int unsigned COLOR_W      = 9;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DIM_W        = 5;

  localparam logic [COLOR_W-1:0] DEF_TRANSPARENT_COLOR = 9'h1C7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FETCH,
    DRAIN,
    DONE
  } blitState_t;

  // Start address of an animation frame; the 13-bit product cannot overflow (7*31*31).
  function automatic logic [ADDR_W-1:0] frameBase(input logic [2:0]       f,
                                                  input logic [DIM_W-1:0] w,
                                                  input logic [DIM_W-1:0] h);
    logic [12:0] prod;
    prod = 13'(f) * 13'(w) * 13'(h);
    return prod[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_blitter_walker.sv
// Row/column/address counters walking one sprite frame in row-major order.
module sprite_pixel_walker
  import sprite_blitter_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [ADDR_W-1:0] addr,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              last
);

  logic [DIM_W-1:0] widthReg;
  logic [DIM_W-1:0] heightReg;
  logic             colWrap;

  assign colWrap = (col == widthReg - DIM_W'(1));
  assign last    = colWrap && (row == heightReg - DIM_W'(1));

  // Row-major order makes the linear address a plain +1 counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr      <= '0;
      col       <= '0;
      row       <= '0;
      widthReg  <= '0;
      heightReg <= '0;
    end else if (load) begin
      addr      <= baseAddr;
      col       <= '0;
      row       <= '0;
      widthReg  <= width;
      heightReg <= height;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (colWrap) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: reads one animation frame from a sprite ROM and writes clipped,
// non-transparent pixels to the framebuffer through a ready/valid write port.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int unsigned        SCREEN_W          = DEF_SCREEN_W,
  parameter int unsigned        SCREEN_H          = DEF_SCREEN_H,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = DEF_TRANSPARENT_COLOR
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Start,
  input  logic [2:0]         SpriteSel,
  input  logic [2:0]         Frame,
  input  logic [7:0]         PosX,
  input  logic [6:0]         PosY,
  output logic               Busy,
  output logic               Done,
  output logic [2:0]         MemSel,
  output logic [ADDR_W-1:0]  Address,
  input  logic [COLOR_W-1:0] MemData,
  input  logic [DIM_W-1:0]   Width,
  input  logic [DIM_W-1:0]   Height,
  input  logic [2:0]         AnimSteps,
  output logic [7:0]         FbX,
  output logic [6:0]         FbY,
  output logic [COLOR_W-1:0] FbColor,
  output logic               FbWrite,
  input  logic               FbReady
);

  blitState_t state, nextState;

  logic [2:0]         selReg;
  logic [2:0]         frameReg;
  logic [7:0]         posXReg;
  logic [6:0]         posYReg;

  logic               walkLoad;
  logic               walkAdvance;
  logic [ADDR_W-1:0]  walkBase;
  logic [2:0]         effFrame;
  logic [DIM_W-1:0]   walkCol;
  logic [DIM_W-1:0]   walkRow;
  logic               walkLast;

  logic               pendValid;
  logic [DIM_W-1:0]   pendCol;
  logic [DIM_W-1:0]   pendRow;
  logic               holdValid;
  logic [COLOR_W-1:0] colorHold;

  logic [COLOR_W-1:0] pixColor;
  logic [8:0]         pixX;
  logic [8:0]         pixY;
  logic               pixKeep;
  logic               fbWrite;
  logic               stall;

  // While stalled the ROM already shows the next word, so the stalled colour is
  // captured on the first stall cycle and replayed until the write is accepted.
  assign pixColor = holdValid ? colorHold : MemData;
  assign pixX     = {1'b0, posXReg} + {4'b0, pendCol};
  assign pixY     = {2'b0, posYReg} + {4'b0, pendRow};
  assign pixKeep  = (pixColor != TRANSPARENT_COLOR) &&
                    (pixX < 9'(SCREEN_W)) && (pixY < 9'(SCREEN_H));
  assign fbWrite  = pendValid && pixKeep;
  assign stall    = fbWrite && !FbReady;

  assign effFrame = (frameReg > AnimSteps) ? 3'd0 : frameReg;
  assign walkBase = frameBase(effFrame, Width, Height);

  sprite_pixel_walker uWalker (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .load     (walkLoad),
    .advance  (walkAdvance),
    .baseAddr (walkBase),
    .width    (Width),
    .height   (Height),
    .addr     (Address),
    .col      (walkCol),
    .row      (walkRow),
    .last     (walkLast)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (Start) nextState = SETUP;
      SETUP:   nextState = (Width == '0 || Height == '0) ? DONE : FETCH;
      FETCH:   if (!stall && walkLast) nextState = DRAIN;
      DRAIN:   if (!stall) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy        = (state != IDLE);
    Done        = (state == DONE);
    walkLoad    = (state == SETUP);
    walkAdvance = (state == FETCH) && !stall;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      selReg    <= '0;
      frameReg  <= '0;
      posXReg   <= '0;
      posYReg   <= '0;
      pendValid <= 1'b0;
      pendCol   <= '0;
      pendRow   <= '0;
      holdValid <= 1'b0;
      colorHold <= '0;
    end else begin
      if (state == IDLE && Start) begin
        selReg   <= SpriteSel;
        frameReg <= Frame;
        posXReg  <= PosX;
        posYReg  <= PosY;
      end
      if (walkLoad) begin
        pendValid <= 1'b0;
      end else if (walkAdvance) begin
        pendValid <= 1'b1;
        pendCol   <= walkCol;
        pendRow   <= walkRow;
      end else if (state == DRAIN && !stall) begin
        pendValid <= 1'b0;
      end
      holdValid <= stall;
      if (stall && !holdValid) colorHold <= MemData;
    end
  end

  assign MemSel  = selReg;
  assign FbWrite = fbWrite;
  assign FbX     = fbWrite ? pixX[7:0] : '0;
  assign FbY     = fbWrite ? pixY[6:0] : '0;
  assign FbColor = fbWrite ? pixColor  : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: sprite ROM model, expected write/address queues.
module tb_sprite_blitter;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [2:0] SpriteSel, Frame;
  logic [7:0] PosX;
  logic [6:0] PosY;
  logic       Busy, Done;
  logic [2:0] MemSel;
  logic [11:0] Address;
  logic [8:0] MemData;
  logic [4:0] Width, Height;
  logic [2:0] AnimSteps;
  logic [7:0] FbX;
  logic [6:0] FbY;
  logic [8:0] FbColor;
  logic       FbWrite, FbReady;

  logic [8:0] rom [8][4096];
  logic [4:0] sprW [8];
  logic [4:0] sprH [8];
  logic [2:0] sprS [8];

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
  } pix_t;

  pix_t expWr[$];
  int   expAddr[$];
  int   compared = 0;
  int   mismatched = 0;

  sprite_blitter dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .SpriteSel(SpriteSel), .Frame(Frame),
    .PosX(PosX), .PosY(PosY), .Busy(Busy), .Done(Done), .MemSel(MemSel), .Address(Address),
    .MemData(MemData), .Width(Width), .Height(Height), .AnimSteps(AnimSteps),
    .FbX(FbX), .FbY(FbY), .FbColor(FbColor), .FbWrite(FbWrite), .FbReady(FbReady)
  );

  always #5 Clock = ~Clock;

  assign Width     = sprW[MemSel];
  assign Height    = sprH[MemSel];
  assign AnimSteps = sprS[MemSel];

  always @(posedge Clock) MemData <= rom[MemSel][Address];

  task automatic runSprite(input logic [2:0] sel, input logic [2:0] frm, input logic [7:0] px,
                           input logic [6:0] py, input int stallPix, input int stallLen,
                           input int junkCyc, input string name);
    int w, h, f, base, n, expDone, cyc, wrCnt, stallCnt, x, y;
    logic [11:0] lastAddr;
    logic doneSeen;
    pix_t exp, held;
    w = int'(sprW[sel]);
    h = int'(sprH[sel]);
    f = (int'(frm) > int'(sprS[sel])) ? 0 : int'(frm);
    base = (f * w * h) % 4096;
    n = w * h;
    expDone = (n == 0) ? 2 : n + 3 + stallLen;
    expWr.delete();
    expAddr.delete();
    for (int k = 0; k < n; k++) begin
      x = int'(px) + k % w;
      y = int'(py) + k / w;
      expAddr.push_back((base + k) % 4096);
      exp.x = 8'(x);
      exp.y = 7'(y);
      exp.c = rom[sel][(base + k) % 4096];
      if (exp.c != 9'h1C7 && x < 160 && y < 120) expWr.push_back(exp);
    end

    @(negedge Clock);
    compared++;
    if (Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idle_busy: got %b want 0", name, Busy);
    end
    Start = 1'b1; SpriteSel = sel; Frame = frm; PosX = px; PosY = py;
    @(negedge Clock);
    Start = 1'b0; SpriteSel = ~sel; Frame = ~frm; PosX = ~px; PosY = ~py;
    cyc = 1; wrCnt = 0; stallCnt = 0; doneSeen = 1'b0; lastAddr = Address;
    held = '{default: '0};

    while (cyc < expDone + 40) begin
      Start = (cyc == junkCyc);
      if (cyc >= 2 && expAddr.size() > 0 && (cyc == 2 || Address != lastAddr)) begin
        compared++;
        if (int'(Address) !== expAddr[0]) begin
          mismatched++;
          $display("FAIL %s address: cycle %0d got %0d want %0d", name, cyc, Address, expAddr[0]);
        end
        void'(expAddr.pop_front());
      end
      lastAddr = Address;
      if (FbWrite && wrCnt == stallPix && stallCnt < stallLen) begin
        if (stallCnt == 0) begin
          held.x = FbX; held.y = FbY; held.c = FbColor;
        end else begin
          compared++;
          if (FbX !== held.x || FbY !== held.y || FbColor !== held.c || Address !== lastAddr) begin
            mismatched++;
            $display("FAIL %s stall_hold: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                     name, FbX, FbY, FbColor, held.x, held.y, held.c);
          end
        end
        FbReady = 1'b0;
        stallCnt++;
      end else begin
        FbReady = 1'b1;
        if (FbWrite) begin
          compared++;
          if (expWr.size() == 0) begin
            mismatched++;
            $display("FAIL %s extra_write: got (%0d,%0d,%h) want none", name, FbX, FbY, FbColor);
          end else begin
            exp = expWr.pop_front();
            if (FbX !== exp.x || FbY !== exp.y || FbColor !== exp.c) begin
              mismatched++;
              $display("FAIL %s write: cycle %0d got (%0d,%0d,%h) want (%0d,%0d,%h)",
                       name, cyc, FbX, FbY, FbColor, exp.x, exp.y, exp.c);
            end
          end
          wrCnt++;
        end
      end
      if (Done) begin
        doneSeen = 1'b1;
        compared++;
        if (cyc != expDone || Busy !== 1'b1) begin
          mismatched++;
          $display("FAIL %s done_cycle: got %0d busy %b want %0d busy 1", name, cyc, Busy, expDone);
        end
        break;
      end
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    FbReady = 1'b1;
    if (!doneSeen) begin
      mismatched++;
      $display("FAIL %s timeout: got no Done want Done at cycle %0d", name, expDone);
    end
    compared++;
    if (expWr.size() != 0 || expAddr.size() != 0) begin
      mismatched++;
      $display("FAIL %s leftover: got %0d writes %0d addrs outstanding want 0 0",
               name, expWr.size(), expAddr.size());
    end
  endtask

  task automatic test_reset();
    compared++;
    if ({Busy, Done, MemSel, Address, FbX, FbY, FbColor, FbWrite} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got busy=%b done=%b sel=%0d addr=%0d fb=(%0d,%0d,%h,%b) want all 0",
               Busy, Done, MemSel, Address, FbX, FbY, FbColor, FbWrite);
    end
  endtask

  task automatic test_basic();
    runSprite(3'd0, 3'd0, 8'd10, 7'd20, -1, 0, -1, "basic");
  endtask

  task automatic test_clip();
    runSprite(3'd0, 3'd0, 8'd156, 7'd115, -1, 0, -1, "clip");
  endtask

  task automatic test_transparent();
    logic [8:0] saved;
    saved = rom[0][5];
    rom[0][5] = 9'h1C7;
    runSprite(3'd0, 3'd0, 8'd10, 7'd20, -1, 0, -1, "transparent");
    rom[0][5] = saved;
  endtask

  task automatic test_frames();
    runSprite(3'd1, 3'd3, 8'd30, 7'd30, -1, 0, -1, "frame3");
    runSprite(3'd1, 3'd5, 8'd0, 7'd0, -1, 0, -1, "frame5_clamped");
  endtask

  task automatic test_stall();
    runSprite(3'd0, 3'd0, 8'd10, 7'd20, 2, 4, -1, "stall");
  endtask

  task automatic test_start_busy();
    runSprite(3'd0, 3'd0, 8'd40, 7'd40, -1, 0, 5, "start_busy");
  endtask

  task automatic test_zero_width();
    runSprite(3'd2, 3'd0, 8'd0, 7'd0, -1, 0, -1, "zero_width");
  endtask

  task automatic test_back_to_back();
    runSprite(3'd3, 3'd1, 8'd100, 7'd100, -1, 0, -1, "b2b_first");
    runSprite(3'd0, 3'd0, 8'd0, 7'd0, -1, 0, -1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    Start = 1'b1; SpriteSel = 3'd0; Frame = 3'd0; PosX = 8'd10; PosY = 7'd20;
    @(negedge Clock);
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    compared++;
    if ({Busy, Done, MemSel, Address, FbX, FbY, FbColor, FbWrite} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: got busy=%b addr=%0d fb=(%0d,%0d,%h,%b) want all 0",
               Busy, Address, FbX, FbY, FbColor, FbWrite);
    end
    repeat (3) begin
      @(negedge Clock);
      compared++;
      if (FbWrite !== 1'b0 || Busy !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold: got write=%b busy=%b want 0 0", FbWrite, Busy);
      end
    end
    Resetn = 1'b1;
    runSprite(3'd3, 3'd0, 8'd5, 7'd5, -1, 0, -1, "after_reset");
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; SpriteSel = '0; Frame = '0; PosX = '0; PosY = '0;
    FbReady = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < 4096; a++) rom[s][a] = 9'((a + s * 13) % 449);
      sprW[s] = 5'd4; sprH[s] = 5'd4; sprS[s] = 3'd1;
    end
    sprW[0] = 5'd8;  sprH[0] = 5'd16; sprS[0] = 3'd0;
    sprW[1] = 5'd16; sprH[1] = 5'd16; sprS[1] = 3'd3;
    sprW[2] = 5'd0;  sprH[2] = 5'd4;  sprS[2] = 3'd0;
    #17;
    test_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    test_basic();
    test_clip();
    test_transparent();
    test_frames();
    test_stall();
    test_start_busy();
    test_zero_width();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
